// File: rtl/defunnel_pkg.sv
// ----------------------------------------------------------------------------
// Module  : defunnel_pkg
// Brief   : Shared encodings, slot count and state type for the defunnel
//           controller and its datapath model.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package defunnel_pkg;

  localparam int NUM_SLOTS = 8;

  localparam logic [2:0] RED_1 = 3'd1;
  localparam logic [2:0] RED_2 = 3'd2;
  localparam logic [2:0] RED_4 = 3'd4;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  // Contiguous run of lanes written by one beat, before shifting to the slot pointer.
  function automatic logic [7:0] lane_run(input logic [2:0] reduct);
    logic [7:0] run;
    run = 8'h00;
    case (reduct)
      RED_1:   run = 8'h01;
      RED_2:   run = 8'h03;
      RED_4:   run = 8'h0F;
      default: run = 8'h00;
    endcase
    return run;
  endfunction

endpackage

`default_nettype wire

// File: rtl/defunnel_ctrl_5_1_if.sv
// ----------------------------------------------------------------------------
// Module  : defunnel_ctrl_5_1_if
// Brief   : Upstream beat / downstream word handshakes and datapath strobes.
//           DEFUNNEL_CTRL_FLUSH_EN adds t_last and i_keep.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface defunnel_ctrl_5_1_if;

  logic [7:0] t_cfg_dat;
  logic       t_valid;
  logic       t_ready;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] enable;
  logic [7:0] mode;
  logic       err;
`ifdef DEFUNNEL_CTRL_FLUSH_EN
  logic       t_last;
  logic [7:0] i_keep;
`endif

  // master: the controller; slave: the surrounding producer/consumer
`ifdef DEFUNNEL_CTRL_FLUSH_EN
  modport master (
    input  t_cfg_dat, t_valid, i_ready, t_last,
    output t_ready, i_valid, enable, mode, err, i_keep
  );
  modport slave (
    output t_cfg_dat, t_valid, i_ready, t_last,
    input  t_ready, i_valid, enable, mode, err, i_keep
  );
`else
  modport master (
    input  t_cfg_dat, t_valid, i_ready,
    output t_ready, i_valid, enable, mode, err
  );
  modport slave (
    output t_cfg_dat, t_valid, i_ready,
    input  t_ready, i_valid, enable, mode, err
  );
`endif

endinterface

`default_nettype wire

// File: rtl/defunnel_ctrl_mask.sv
// ----------------------------------------------------------------------------
// Module  : defunnel_ctrl_mask
// Brief   : Decodes (reduct, ptr) into the 8-bit slot capture mask and flags
//           whether the reduct encoding is legal.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module defunnel_ctrl_mask
  import defunnel_pkg::*;
(
  input  logic [2:0] reduct,
  input  logic [2:0] ptr,
  output logic [7:0] mask,
  output logic       legal
);

  logic [7:0] run;

  always_comb begin
    run   = lane_run(reduct);
    legal = (run != 8'h00);
    mask  = run << ptr;
  end

endmodule

`default_nettype wire

// File: rtl/defunnel_ctrl_5_1.sv
// ----------------------------------------------------------------------------
// Module  : defunnel_ctrl_5_1
// Brief   : Packs 1/2/4-lane beats into 8-slot words; DEFUNNEL_CTRL_FLUSH_EN
//           enables early word termination with t_last and an i_keep mask.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module defunnel_ctrl_5_1 #(
  parameter int NUM_SLOTS = 8
) (
  input  logic                clk,
  input  logic                reset,
  defunnel_ctrl_5_1_if.master bus
);

  import defunnel_pkg::*;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] mode_q, mode_d;
  logic       err_q, err_d;

  logic [7:0] mode_w;
  logic [7:0] slot_mask;
  logic       legal;
  logic       t_ready_w;
  logic       accepted;
  logic       beat_last;
  logic       word_done;
  logic [3:0] ptr_sum;

  // New config is only sampled at a word boundary; mid-word the latched mode rules.
  assign mode_w    = (ptr_q == 3'd0) ? bus.t_cfg_dat : mode_q;
  assign t_ready_w = !reset && ((state_q == FILL) || bus.i_ready);
  assign accepted  = bus.t_valid && t_ready_w;
  assign ptr_sum   = {1'b0, ptr_q} + {1'b0, mode_w[2:0]};

  defunnel_ctrl_mask u_mask (
    .reduct (mode_w[2:0]),
    .ptr    (ptr_q),
    .mask   (slot_mask),
    .legal  (legal)
  );

`ifdef DEFUNNEL_CTRL_FLUSH_EN
  assign beat_last = bus.t_last;
`else
  assign beat_last = 1'b0;
`endif

  always_comb begin
    ptr_d     = ptr_q;
    mode_d    = mode_q;
    err_d     = err_q;
    state_d   = state_q;
    word_done = 1'b0;

    if (accepted && (ptr_q == 3'd0)) begin
      mode_d = bus.t_cfg_dat;
    end
    if (accepted && !legal) begin
      err_d = 1'b1;
    end
    if (accepted && legal) begin
      word_done = (ptr_sum >= 4'(NUM_SLOTS)) || beat_last;
      ptr_d     = word_done ? 3'd0 : ptr_sum[2:0];
    end

    // A completing beat in the hand-off cycle keeps the word slot occupied.
    if (word_done) begin
      state_d = FULL;
    end else if ((state_q == FULL) && bus.i_ready) begin
      state_d = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      ptr_q   <= 3'd0;
      mode_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

`ifdef DEFUNNEL_CTRL_FLUSH_EN
  logic [7:0] keep_q, keep_d;

  always_comb begin
    keep_d = keep_q;
    if (state_q == FULL) begin
      if (bus.i_ready) begin
        keep_d = accepted && legal ? slot_mask : 8'h00;
      end
    end else if (accepted && legal) begin
      keep_d = keep_q | slot_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keep_q <= 8'h00;
    end else begin
      keep_q <= keep_d;
    end
  end

  assign bus.i_keep = keep_q;
`endif

  assign bus.t_ready = t_ready_w;
  assign bus.i_valid = (state_q == FULL) && !reset;
  assign bus.enable  = (accepted && legal) ? slot_mask : 8'h00;
  assign bus.mode    = mode_w;
  assign bus.err     = err_q;

endmodule

`default_nettype wire

// File: doc/defunnel_ctrl_5_1.md
DEFUNNEL_CTRL_5_1 -- requirements
Module: defunnel_ctrl_5_1

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: t_cfg_dat  in  8  requested mode; [2:0] = reduct, the lanes per beat (1, 2 or 4); [7:3] passed through.
REQ-004 SHALL have ports: t_valid  in  1 / t_ready  out  1  upstream beat handshake (4x128-bit lanes held on the datapath).
REQ-005 SHALL have ports: i_valid  out  1 / i_ready  in  1  downstream 1024-bit word handshake.
REQ-006 SHALL have ports: enable  out  8  per-slot capture strobes to the defunnel datapath.
REQ-007 SHALL have ports: mode  out  8  config driven to the datapath t_cfg_dat.
REQ-008 SHALL have ports: err  out  1  sticky illegal-reduct flag.
REQ-009 SHALL have parameter NUM_SLOTS, default 8, meaning the 128-bit slots per output word; only 8 is supported.

Function
REQ-010 SHALL hold slot pointer ptr[2:0], word-mode register mode_q[7:0] and state in {FILL, FULL}.
REQ-011 SHALL drive mode = (ptr==0) ? t_cfg_dat : mode_q, combinationally; the reduct in use is mode[2:0].
REQ-012 SHALL load mode_q <= t_cfg_dat on each accepted beat with ptr==0, so mode changes take effect only at word boundaries.
REQ-013 SHALL drive t_ready = (state==FILL) | (i_ready & state==FULL) and hold it low during reset.
REQ-014 SHALL define a beat as accepted when t_valid & t_ready.
REQ-015 SHALL drive enable = accepted ? (((1<<reduct)-1) << ptr) : 8'h00, combinationally in the same cycle as the accepted beat.
REQ-016 SHALL advance ptr by reduct per accepted beat, modulo 8; for reduct=1/2/4 a word takes 8/4/2 beats respectively.
REQ-017 SHALL move FILL->FULL when an accepted beat makes ptr wrap to 0; i_valid=1 exactly when state==FULL, starting the cycle after the last beat.
REQ-018 SHALL, in FULL with i_ready=1, return to FILL; if a beat is accepted in that same cycle it writes slot 0 (flow-through), giving 1 word per 8/reduct cycles sustained.
REQ-019 SHALL hold i_valid until i_ready and accept no beat while i_valid & !i_ready; datapath slots SHALL never be overwritten before hand-off.
REQ-020 SHALL treat reduct not in {1,2,4} at ptr==0 as illegal: the beat is accepted (t_ready high), enable=0, ptr is unchanged, err is set to 1.
REQ-021 SHALL keep err sticky until reset.
REQ-022 SHALL ignore t_cfg_dat changes while ptr!=0.

Reset
REQ-023 SHALL, on reset, give: ptr=0, state=FILL, mode_q=0, err=0, i_valid=0, t_ready=0, enable=0; any partial word is discarded.
REQ-024 SHALL give reset priority over all simultaneous handshake events; the first beat can be accepted the cycle after reset deasserts.

Configuration
REQ-025 SHALL, with DEFUNNEL_CTRL_FLUSH_EN defined, add ports t_last (in, 1) and i_keep (out, 8).
REQ-026 SHALL, with DEFUNNEL_CTRL_FLUSH_EN defined, end the word after an accepted beat with t_last=1 (go to FULL, ptr=0); i_keep SHALL mark the written slots (8'hFF for a full word).
REQ-027 SHALL, without the macro, have no t_last/i_keep ports; words complete only on ptr wrap.

Structure
REQ-028 SHALL place the following in shared package defunnel_pkg: reduct encodings RED_1=3'd1, RED_2=3'd2, RED_4=3'd4; NUM_SLOTS=8; FILL/FULL state enum.
REQ-029 SHALL implement the slot-mask decode (reduct, ptr -> 8-bit mask) as one sub-module, defunnel_ctrl_mask, shared with the datapath testbench model.

Verification
REQ-030 SHALL cover: reduct=1, 8 back-to-back beats, i_ready=1 -> enable walks 01,02,..,80; i_valid high in cycle 9 only.
REQ-031 SHALL cover: reduct=4, continuous t_valid, i_ready=1 -> enable alternates 0F,F0; a word every 2 cycles; t_ready never drops.
REQ-032 SHALL cover: reduct=2, i_ready=0 for 5 cycles after the word fills -> t_ready=0 and enable=00 throughout; the word is held, and 4 beats follow once i_ready=1.
REQ-033 SHALL cover: t_cfg_dat switches 2->4 at ptr=4 -> mode stays 2 until the wrap; the next word uses enable 0F,F0.
REQ-034 SHALL cover: reduct=3 at ptr=0 -> enable=00, ptr stays 0, err=1 and stays 1 through later legal words until reset.
REQ-035 SHALL cover: reset asserted with ptr=6 and i_valid=0 -> next cycle ptr=0, no i_valid; the next 8 reduct=1 beats form a clean word.
